// File: rtl/game_counter_pkg.sv
// ---------------------------------------------------------------------------
// game_counter_pkg
// Shared definitions for the game step counter slice.
//   DIR_UP / DIR_DOWN : encoding of the `up` direction input
//   step_cmd_t        : per-edge next-state decode (HOLD < STEP < LOAD < CLEAR)
//   clog2()           : ceiling log2 used to size the prescaler register
// Optional build macro used by the counter: GAME_STEP_COUNTER_SATURATE_EN
// ---------------------------------------------------------------------------
package game_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STEP  = 2'd1,
    LOAD  = 2'd2,
    CLEAR = 2'd3
  } step_cmd_t;

  // Ceiling log2; returns 0 for values <= 1. Callers enforce a 1-bit minimum.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/game_step_counter_prescaler.sv
// ---------------------------------------------------------------------------
// step_prescaler
// Divides qualified `en` cycles by PRESCALE and produces a one-cycle `tick`
// on the last cycle of each phase.
// Parameters:
//   PRESCALE : en-cycles per tick (1..65535); 1 makes tick follow en directly
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  synchronous active-low reset (clears the phase counter)
//   en    in  advance enable; the phase counter holds while low
//   clear in  synchronous clear of the phase counter
//   tick  out combinational strobe: en && (pcnt == PRESCALE-1)
// There is no handshake on any port: inputs act on the edge they are sampled.
// ---------------------------------------------------------------------------
module step_prescaler
  import game_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  // A PRESCALE of 1 would give a zero-width counter; keep one constant bit.
  localparam int PCNT_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;

  assign tick = en && (pcnt_q == PCNT_LAST);

  // Load in the parent does not touch the phase, so only clear and the
  // wrap-on-tick return pcnt to zero.
  always_comb begin
    pcnt_d = pcnt_q;
    if (clear || tick) begin
      pcnt_d = '0;
    end else if (en) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/game_step_counter.sv
// ---------------------------------------------------------------------------
// game_step_counter
// Clock-enabled up/down counter with programmable modulus, enable prescaler,
// synchronous clear/load and a registered terminal-count pulse. Everything
// runs on `clk`; there is no clock gating and no asynchronous path.
// Parameters:
//   WIDTH    : count width in bits (1..16)
//   MAX      : highest count value, count range 0..MAX (MAX <= 2**WIDTH-1)
//   PRESCALE : qualified en-cycles per count step (1..65535)
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  synchronous active-low reset
//   en       in  count enable (advances the prescaler)
//   up       in  direction, 1 = up, 0 = down
//   clear    in  synchronous clear of count and prescaler
//   load     in  synchronous load of load_val (clamped to MAX)
//   load_val in  value to load
//   count    out registered count
//   tick     out combinational prescaler strobe
//   tc       out registered one-cycle terminal-count pulse
//   zero     out combinational count == 0
// Edge priority: rst > clear > load > step > hold. No handshake: clear and
// load act on the edge where they are sampled high, with no back-pressure.
// Build option: define GAME_STEP_COUNTER_SATURATE_EN to hold at the limits
// instead of wrapping; tc then pulses on each blocked step.
// ---------------------------------------------------------------------------
module game_step_counter
  import game_counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  step_cmd_t        cmd;
  logic [WIDTH-1:0] load_clamped;
  logic             at_limit;

  step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clear),
    .tick  (tick)
  );

  // Priority decode of what this edge does to count/tc.
  always_comb begin
    cmd = HOLD;
    if (clear) begin
      cmd = CLEAR;
    end else if (load) begin
      cmd = LOAD;
    end else if (tick) begin
      cmd = STEP;
    end
  end

  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  // The limit a step would cross depends on the direction being stepped.
  assign at_limit = (up == DIR_UP) ? (count_q == MAX_V) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    unique case (cmd)
      CLEAR: count_d = '0;
      LOAD:  count_d = load_clamped;
      STEP: begin
        if (at_limit) begin
          tc_d = 1'b1;
`ifdef GAME_STEP_COUNTER_SATURATE_EN
          count_d = count_q;
`else
          count_d = (up == DIR_UP) ? '0 : MAX_V;
`endif
        end else if (up == DIR_UP) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign zero  = (count_q == '0);

endmodule

// File: doc/game_step_counter.md
# game_step_counter

Parametrised, clock-enabled up/down counter with programmable modulus, built-in enable prescaler, synchronous load/clear and a terminal-count pulse. It supersedes the fixed 5/6-bit ripple-toggle counters and no longer gates the clock. Every state element runs on `clk`, so the counter can drive alien-march stepping, animation frame indices and fire-cooldown timers from one common clock domain.

## Interface
Parameters:
- WIDTH, 5, count register width in bits (1..16).
- MAX, 2**WIDTH-1, highest count value; count range is 0..MAX; must satisfy MAX ≤ 2**WIDTH-1.
- PRESCALE, 1, number of qualified `en` cycles per count step (1..65535); 1 means step on every `en` cycle.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  count enable; the prescaler advances only while high.
- up  in  1  direction: 1 counts up, 0 counts down.
- clear  in  1  synchronous clear of count and prescaler.
- load  in  1  synchronous load of `load_val`.
- load_val  in  WIDTH  value to load; clamped to MAX.
- count  out  WIDTH  current count, registered.
- tick  out  1  prescaler strobe, combinational: en && (pcnt == PRESCALE-1).
- tc  out  1  registered one-cycle terminal-count pulse.
- zero  out  1  combinational flag: count == 0.

## Operation
- Internal prescaler `pcnt` has width clog2(PRESCALE), minimum 1 bit. Its range is 0..PRESCALE-1.
  - Increments on each cycle with en=1.
  - Returns to 0 on tick.
  - Holds while en=0.
- A step occurs on a cycle with tick=1 and no clear or load.
  - Up step: count+1.
  - Down step: count-1.
- Priority per edge is rst (low) > clear > load > step > hold.
- rst low forces count=0, pcnt=0 and tc=0.
- clear forces count=0 and pcnt=0. tc=0 on that edge.
- load sets count=min(load_val, MAX) and leaves pcnt unchanged. tc=0 on that edge.
- Wrap mode (default):
  - An up step from MAX gives count=0 and tc=1 on the next cycle.
  - A down step from 0 gives count=MAX and tc=1.
- tc is 1 only on the cycle after a wrapping step, otherwise 0. Back-to-back wraps (MAX=0, PRESCALE=1) hold tc high continuously.
- Direction change takes effect on the next step. No state is retained per direction.
- Reset mid-count fully discards the prescaler phase. The first step after reset happens PRESCALE en-cycles later.

## Timing
- Reset values: count=0, tc=0, pcnt=0. Derived outputs after reset: zero=1, tick=en when PRESCALE=1, otherwise 0.
- Step latency: count and tc update on the same rising edge at which tick=1 is sampled. Both are visible one cycle later.
- tick and zero are combinational from registered state plus `en`. Consumers must register them.
- Load and clear act on the edge where they are sampled high. There is no handshake and no back-pressure.
- There is no clock gating anywhere, and no asynchronous paths.

## Configuration
- `GAME_STEP_COUNTER_SATURATE_EN` defined:
  - An up step at MAX holds MAX.
  - A down step at 0 holds 0.
  - tc pulses for one cycle on each such blocked step.
  - The prescaler keeps running normally.
- Macro undefined: wrap behaviour as described under Operation.
- load and clear behaviour is identical in both builds.

## Structure
- Shared package `game_counter_pkg`:
  - Constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
  - Function `clog2` for sizing pcnt.
  - Typedef `step_cmd_t` (enum HOLD, STEP, LOAD, CLEAR) for the next-state priority decode.
- One sub-module, `step_prescaler`.
  - Ports: clk, rst, en, clear, tick.
  - Parameter: PRESCALE.
  - Owns pcnt and generates tick; the parent owns count and tc.

## Test plan
- Reset and basic stepping: WIDTH=5, MAX=31, PRESCALE=1, up=1, en=1 after rst release → count 0,1,2,…,31,0. tc high exactly on the cycle count shows 0 after 31. zero high at count 0.
- Modulus and prescale: MAX=23, PRESCALE=3, en=1 → count advances once every 3 cycles, tick high every 3rd cycle, 23→0 wrap with tc pulse. Dropping en for 5 cycles mid-phase delays the next step by exactly 5 cycles.
- Down count and clamp: load with load_val=30 and MAX=23 → count=23. Then up=0 → 22…0, then 0→23 with tc=1.
- Priority: clear, load and tick all high on one edge → count=0, pcnt=0, tc=0. load and tick high with load_val=7 → count=7, tc=0.
- Reset mid-operation: assert rst low at count=12 with pcnt=1 (PRESCALE=3) → next cycle count=0, tc=0. After release, the first step comes 3 en-cycles later.
- Saturate build (`GAME_STEP_COUNTER_SATURATE_EN`): MAX=9, up=1 → count stops at 9, tc pulses on each blocked step. Then up=0 → decrements to 0 and holds with tc pulses.
